dwsamp_phase_ctrl: RTL and testbench
====================================

Name: dwsamp_phase_ctrl

Overview:
- Timing and sequencing controller for the tx→noise→channel filter→anti-alias filter→downsample-by-2 chain.
- Generates the tx polyphase select and the symbol-rate strobe.
- Holds off receiver-side valid until the FIR chain has filled.
- Generates the downsampler enable with a programmable sampling phase, adjusted by a req/ack handshake from later receiver logic (FSE/timing recovery).

Parameters:
- OVERSAMP, 4, samples per symbol at the clk rate; power of 2, ≥2.
- DW_FACTOR, 2, receiver downsample factor; power of 2; divides OVERSAMP.
- FILL_LATENCY, 34, clk cycles from start until the AA filter output is valid (17+17 taps); ≥1.
- PHASE_W, 2, width of the polyphase select; equals log2(OVERSAMP).
- DWPH_W, 1, width of the downsample phase; equals max(1, log2(DW_FACTOR)).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  run request; level.
- i_phase_req  in  1  downsample phase-shift request; level, held until o_phase_ack.
- i_phase_dir  in  1  1 = advance (dw_phase+1), 0 = retard (dw_phase−1); sampled with the request.
- o_phase_ack  out  1  one-cycle acknowledge, asserted when the new phase is applied.
- o_phase_sel  out  PHASE_W  tx polyphase coefficient phase (phase_cnt).
- o_strobe_sym  out  1  symbol-rate strobe for the PRBS and tx filters.
- o_strobe_dw  out  1  downsampler enable.
- o_dw_phase  out  DWPH_W  current downsample phase.
- o_rx_valid  out  1  receiver-side data valid.
- o_state  out  2  FSM state (IDLE=0, FILL=1, RUN=2, ADJ=3).

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE, phase_cnt=0, fill_cnt=0, dw_phase=0, req_armed=1, all outputs 0. Applies immediately, including mid-operation.
- Registers: phase_cnt (PHASE_W), fill_cnt (≥ log2(FILL_LATENCY)+1 bits), dw_phase, req_armed, o_phase_ack, state.
- Decoded outputs (combinational from registers only):
  - o_phase_sel = phase_cnt.
  - o_strobe_sym = (state≠IDLE) && phase_cnt==OVERSAMP−1.
  - o_rx_valid = state∈{RUN,ADJ}.
  - o_strobe_dw = o_rx_valid && (phase_cnt mod DW_FACTOR)==dw_phase.
- phase_cnt: held at 0 in IDLE; otherwise increments every cycle and wraps OVERSAMP−1→0.
- IDLE: if i_enable=1 → FILL; phase_cnt←0, fill_cnt←0.
- FILL: fill_cnt increments each cycle. When fill_cnt==FILL_LATENCY−1 → RUN, so FILL lasts exactly FILL_LATENCY cycles. Requests present during FILL are not serviced; they stay pending.
- RUN: if i_phase_req && req_armed → ADJ; latch i_phase_dir.
- ADJ: wait for the cycle with phase_cnt==OVERSAMP−1. At that edge:
  - dw_phase ← dw_phase±1 mod DW_FACTOR (wraps both ways).
  - o_phase_ack←1 for exactly one cycle.
  - req_armed←0.
  - state→RUN.
  - New phase takes effect from phase_cnt=0 of the next symbol. One missed or extra o_strobe_dw around the boundary is intended.
- req_armed: set again on any cycle with i_phase_req=0. A request held high after ack is never serviced twice.
- i_enable=0 in any non-IDLE state → IDLE at next edge. Clears phase_cnt, fill_cnt and dw_phase; sets req_armed=1; no ack is issued for an in-progress ADJ. Has priority over every other transition.
- Simultaneous: i_enable=0 on the ADJ completion edge → IDLE, no ack.
- o_state=3 is only ever reached via RUN.

Test Plan:
- Reset: run to RUN with dw_phase=1, drive i_reset=0 asynchronously between edges → all outputs 0 before the next edge; after release, state stays IDLE while i_enable=0.
- Startup: i_enable=1 at edge 0 → o_phase_sel runs 0,1,2,3,…; o_strobe_sym high at cycles 3,7,11,…; o_rx_valid low for cycles 0–33 and high from cycle 34; o_strobe_dw first high at cycle 34 (phase_cnt=2), then every 2 cycles at phase_cnt 0,2.
- Advance: in RUN, i_phase_req=1, i_phase_dir=1 at phase_cnt=1 → ADJ; ack one cycle after the phase_cnt=3 edge; o_dw_phase 0→1; o_strobe_dw then at phase_cnt 1,3.
- Retard with wrap: from dw_phase=0, dir=0 → dw_phase=1, single ack; repeat from 1 → 0.
- Handshake: hold i_phase_req=1 for 20 cycles → exactly one ack. Drop for 1 cycle and raise again → second ack at the next symbol boundary. Request raised during FILL → serviced at the first boundary after RUN entry.
- Disable mid-ADJ: i_enable=0 while state=3 → state=0 next cycle, no ack pulse, o_dw_phase=0, all strobes 0. Re-enable → full 34-cycle FILL repeats.

Source files
------------

// File: rtl/dwsamp_phase_ctrl.sv
// -----------------------------------------------------------------------------
// dwsamp_phase_ctrl
//
// Timing and sequencing controller for the tx -> noise -> channel filter ->
// anti-alias filter -> downsample-by-DW_FACTOR chain.
//
// Functions:
//   - Free-running polyphase counter (phase_cnt) that selects the tx
//     coefficient phase and produces the symbol-rate strobe.
//   - Holds receiver-side valid low until the FIR chain has filled
//     (FILL_LATENCY cycles after enable).
//   - Generates the downsampler enable at a programmable sampling phase.
//     Later receiver logic (FSE / timing recovery) can shift this phase by
//     one step with a req/ack handshake. The shift is applied only at a
//     symbol boundary.
//
// Ports:
//   clk          system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_enable     run request (level); dropping it returns to IDLE
//   i_phase_req  phase-shift request, held until o_phase_ack
//   i_phase_dir  1 = advance dw_phase, 0 = retard (sampled with the request)
//   o_phase_ack  one-cycle acknowledge when the new phase is applied
//   o_phase_sel  tx polyphase select (phase_cnt)
//   o_strobe_sym symbol-rate strobe
//   o_strobe_dw  downsampler enable
//   o_dw_phase   current downsample phase
//   o_rx_valid   receiver-side data valid
//   o_state      FSM state (IDLE=0, FILL=1, RUN=2, ADJ=3)
// -----------------------------------------------------------------------------
module dwsamp_phase_ctrl #(
    parameter int OVERSAMP     = 4,
    parameter int DW_FACTOR    = 2,
    parameter int FILL_LATENCY = 34,
    parameter int PHASE_W      = 2,
    parameter int DWPH_W       = 1
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_phase_req,
    input  logic               i_phase_dir,
    output logic               o_phase_ack,
    output logic [PHASE_W-1:0] o_phase_sel,
    output logic               o_strobe_sym,
    output logic               o_strobe_dw,
    output logic [DWPH_W-1:0]  o_dw_phase,
    output logic               o_rx_valid,
    output logic [1:0]         o_state
);

    localparam int FILL_W = $clog2(FILL_LATENCY) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_ADJ  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [PHASE_W-1:0]  phase_cnt_reg, phase_cnt_next;
    logic [FILL_W-1:0]   fill_cnt_reg, fill_cnt_next;
    logic [DWPH_W-1:0]   dw_phase_reg, dw_phase_next;
    logic                req_armed_reg, req_armed_next;
    logic                phase_ack_reg, phase_ack_next;
    logic                dir_reg, dir_next;

    logic                symbol_end;
    logic [DWPH_W-1:0]   dw_phase_inc;
    logic [DWPH_W-1:0]   dw_phase_dec;

    assign symbol_end = (phase_cnt_reg == PHASE_W'(OVERSAMP - 1));

    // dw_phase is exactly log2(DW_FACTOR) bits wide, so plain +/-1 wraps
    // modulo DW_FACTOR. With no downsampling there is only phase 0.
    generate
        if (DW_FACTOR > 1) begin : g_dw_wrap
            assign dw_phase_inc = dw_phase_reg + DWPH_W'(1);
            assign dw_phase_dec = dw_phase_reg - DWPH_W'(1);
        end else begin : g_dw_single
            assign dw_phase_inc = '0;
            assign dw_phase_dec = '0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg     <= ST_IDLE;
            phase_cnt_reg <= '0;
            fill_cnt_reg  <= '0;
            dw_phase_reg  <= '0;
            req_armed_reg <= 1'b1;
            phase_ack_reg <= 1'b0;
            dir_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            fill_cnt_reg  <= fill_cnt_next;
            dw_phase_reg  <= dw_phase_next;
            req_armed_reg <= req_armed_next;
            phase_ack_reg <= phase_ack_next;
            dir_reg       <= dir_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        fill_cnt_next  = fill_cnt_reg;
        dw_phase_next  = dw_phase_reg;
        // Re-arm on any cycle with the request low, so a request held high
        // past its ack is never serviced a second time.
        req_armed_next = req_armed_reg | ~i_phase_req;
        phase_ack_next = 1'b0;
        dir_next       = dir_reg;

        // OVERSAMP is a power of two, so the counter wraps naturally.
        if (state_reg != ST_IDLE) begin
            phase_cnt_next = phase_cnt_reg + PHASE_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                phase_cnt_next = '0;
                if (i_enable) begin
                    state_next    = ST_FILL;
                    fill_cnt_next = '0;
                end
            end
            ST_FILL: begin
                // Requests arriving here stay pending until RUN.
                fill_cnt_next = fill_cnt_reg + FILL_W'(1);
                if (fill_cnt_reg == FILL_W'(FILL_LATENCY - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_phase_req && req_armed_reg) begin
                    state_next = ST_ADJ;
                    dir_next   = i_phase_dir;
                end
            end
            ST_ADJ: begin
                // Apply on the last sample of the symbol so the new phase
                // is in effect from phase_cnt=0 of the next symbol.
                if (symbol_end) begin
                    dw_phase_next  = dir_reg ? dw_phase_inc : dw_phase_dec;
                    phase_ack_next = 1'b1;
                    req_armed_next = ~i_phase_req;
                    state_next     = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Disable wins over everything, including an ADJ completing on the
        // same edge (no ack is issued then).
        if ((state_reg != ST_IDLE) && !i_enable) begin
            state_next     = ST_IDLE;
            phase_cnt_next = '0;
            fill_cnt_next  = '0;
            dw_phase_next  = '0;
            req_armed_next = 1'b1;
            phase_ack_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Decoded outputs (registers only)
    // -------------------------------------------------------------------------
    assign o_phase_sel  = phase_cnt_reg;
    assign o_phase_ack  = phase_ack_reg;
    assign o_dw_phase   = dw_phase_reg;
    assign o_state      = state_reg;
    assign o_strobe_sym = (state_reg != ST_IDLE) && symbol_end;
    assign o_rx_valid   = (state_reg == ST_RUN) || (state_reg == ST_ADJ);
    assign o_strobe_dw  = o_rx_valid &&
                          ((phase_cnt_reg & PHASE_W'(DW_FACTOR - 1)) == PHASE_W'(dw_phase_reg));

endmodule

// File: tb/tb_dwsamp_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dwsamp_phase_ctrl
//
// Directed bench for dwsamp_phase_ctrl (OVERSAMP=4, DW_FACTOR=2,
// FILL_LATENCY=34). Expected values are hand-derived: after enable is
// sampled at edge 0, cycle n has phase_sel = n mod 4, FILL covers cycles
// 0..33 and RUN starts at cycle 34 (phase_sel = 2).
// -----------------------------------------------------------------------------
module tb_dwsamp_phase_ctrl;

    localparam int OVERSAMP     = 4;
    localparam int DW_FACTOR    = 2;
    localparam int FILL_LATENCY = 34;
    localparam int PHASE_W      = 2;
    localparam int DWPH_W       = 1;

    logic               clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_enable = 1'b0;
    logic               i_phase_req = 1'b0;
    logic               i_phase_dir = 1'b0;
    logic               o_phase_ack;
    logic [PHASE_W-1:0] o_phase_sel;
    logic               o_strobe_sym;
    logic               o_strobe_dw;
    logic [DWPH_W-1:0]  o_dw_phase;
    logic               o_rx_valid;
    logic [1:0]         o_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dwsamp_phase_ctrl #(
        .OVERSAMP    (OVERSAMP),
        .DW_FACTOR   (DW_FACTOR),
        .FILL_LATENCY(FILL_LATENCY),
        .PHASE_W     (PHASE_W),
        .DWPH_W      (DWPH_W)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_phase_req (i_phase_req),
        .i_phase_dir (i_phase_dir),
        .o_phase_ack (o_phase_ack),
        .o_phase_sel (o_phase_sel),
        .o_strobe_sym(o_strobe_sym),
        .o_strobe_dw (o_strobe_dw),
        .o_dw_phase  (o_dw_phase),
        .o_rx_valid  (o_rx_valid),
        .o_state     (o_state)
    );

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all(input string tag, input int st, input int sel, input int sym,
                             input int sdw, input int vld, input int ack, input int dwph);
        check_val({tag, "_state"},  32'(o_state),      32'(st));
        check_val({tag, "_sel"},    32'(o_phase_sel),  32'(sel));
        check_val({tag, "_sym"},    32'(o_strobe_sym), 32'(sym));
        check_val({tag, "_sdw"},    32'(o_strobe_dw),  32'(sdw));
        check_val({tag, "_valid"},  32'(o_rx_valid),   32'(vld));
        check_val({tag, "_ack"},    32'(o_phase_ack),  32'(ack));
        check_val({tag, "_dwph"},   32'(o_dw_phase),   32'(dwph));
    endtask

    // One phase-shift handshake from RUN: raise the request, wait (bounded)
    // for the ack, which must land at phase_sel=0 with the new phase.
    task automatic shift_phase(input string tag, input logic dir, input int exp_dw);
        int acks;
        int waited;
        acks   = 0;
        waited = 0;
        i_phase_req = 1'b1;
        i_phase_dir = dir;
        while (acks == 0 && waited < 12) begin
            tick();
            waited++;
            if (o_phase_ack) begin
                acks++;
                check_val({tag, "_ack_sel"}, 32'(o_phase_sel), 32'd0);
            end
        end
        check_val({tag, "_ack_cnt"}, 32'(acks), 32'd1);
        check_val({tag, "_dw"}, 32'(o_dw_phase), 32'(exp_dw));
        i_phase_req = 1'b0;
        tick();
        check_val({tag, "_ack_len"}, 32'(o_phase_ack), 32'd0);
        $display("shift %s dir=%0d dw_phase=%0d wait=%0d", tag, dir, o_dw_phase, waited);
    endtask

    initial begin
        int acks;
        int waited;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check_all("rst", 0, 0, 0, 0, 0, 0, 0);
        i_reset = 1'b1;
        repeat (3) tick();
        check_all("idle", 0, 0, 0, 0, 0, 0, 0);

        // ---------------- startup ----------------
        i_enable = 1'b1;
        cyc = -1;
        for (int k = 0; k <= 40; k++) begin
            tick();
            check_val("start_sel",   32'(o_phase_sel),  32'(cyc % 4));
            check_val("start_sym",   32'(o_strobe_sym), 32'((cyc % 4) == 3));
            check_val("start_valid", 32'(o_rx_valid),   32'(cyc >= 34));
            check_val("start_sdw",   32'(o_strobe_dw),  32'((cyc >= 34) && (cyc % 2 == 0)));
            check_val("start_state", 32'(o_state),      32'((cyc >= 34) ? 2 : 1));
        end
        $display("startup done at cycle %0d", cyc);

        // ---------------- advance, exact timing ----------------
        tick();                                    // cycle 41, phase 1
        i_phase_req = 1'b1;
        i_phase_dir = 1'b1;
        tick();                                    // phase 2
        check_all("adv_c1", 3, 2, 0, 1, 1, 0, 0);
        tick();                                    // phase 3
        check_all("adv_c2", 3, 3, 1, 0, 1, 0, 0);
        tick();                                    // phase 0, ack
        check_all("adv_c3", 2, 0, 0, 0, 1, 1, 1);
        i_phase_req = 1'b0;
        tick();
        check_all("adv_c4", 2, 1, 0, 1, 1, 0, 1);
        tick();
        check_all("adv_c5", 2, 2, 0, 0, 1, 0, 1);
        tick();
        check_all("adv_c6", 2, 3, 1, 1, 1, 0, 1);
        $display("shift adv dir=1 dw_phase=%0d", o_dw_phase);

        // ---------------- retard, including wrap ----------------
        shift_phase("ret_1to0", 1'b0, 0);
        shift_phase("ret_wrap", 1'b0, 1);
        shift_phase("adv_wrap", 1'b1, 0);

        // ---------------- held request: one ack only ----------------
        i_phase_req = 1'b1;
        i_phase_dir = 1'b1;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_phase_ack) acks++;
        end
        check_val("hold_acks", 32'(acks), 32'd1);
        check_val("hold_dw", 32'(o_dw_phase), 32'd1);
        check_val("hold_state", 32'(o_state), 32'd2);
        $display("hold 20 cycles acks=%0d dw_phase=%0d", acks, o_dw_phase);

        // drop for one cycle, raise again -> second ack
        i_phase_req = 1'b0;
        tick();
        i_phase_req = 1'b1;
        acks = 0;
        waited = 0;
        while (acks == 0 && waited < 8) begin
            tick();
            waited++;
            if (o_phase_ack) begin
                acks++;
                check_val("rearm_ack_sel", 32'(o_phase_sel), 32'd0);
            end
        end
        check_val("rearm_acks", 32'(acks), 32'd1);
        check_val("rearm_dw", 32'(o_dw_phase), 32'd0);
        i_phase_req = 1'b0;
        tick();
        $display("rearm acks=%0d wait=%0d dw_phase=%0d", acks, waited, o_dw_phase);

        // ---------------- disable mid-ADJ ----------------
        shift_phase("pre_dis", 1'b1, 1);
        waited = 0;
        while (o_phase_sel != 0 && waited < 8) begin
            tick();
            waited++;
        end
        check_val("dis_align", 32'(o_phase_sel), 32'd0);
        i_phase_req = 1'b1;
        i_phase_dir = 1'b1;
        tick();
        check_val("dis_in_adj", 32'(o_state), 32'd3);
        i_enable = 1'b0;
        tick();
        check_all("dis", 0, 0, 0, 0, 0, 0, 0);
        $display("disable mid-ADJ state=%0d dw_phase=%0d", o_state, o_dw_phase);

        // ---------------- re-enable with request pending in FILL ----------------
        i_enable = 1'b1;
        cyc = -1;
        acks = 0;
        for (int k = 0; k < FILL_LATENCY; k++) begin
            tick();
            check_val("refill_state", 32'(o_state), 32'd1);
            check_val("refill_valid", 32'(o_rx_valid), 32'd0);
            if (o_phase_ack) acks++;
        end
        check_val("refill_no_ack", 32'(acks), 32'd0);
        tick();                                    // cycle 34
        check_all("refill_run", 2, 2, 0, 1, 1, 0, 0);
        tick();                                    // cycle 35
        check_all("refill_adj", 3, 3, 1, 0, 1, 0, 0);
        tick();                                    // cycle 36
        check_all("refill_ack", 2, 0, 0, 0, 1, 1, 1);
        i_phase_req = 1'b0;
        tick();
        check_val("refill_ack_len", 32'(o_phase_ack), 32'd0);
        $display("fill-pending request acked dw_phase=%0d", o_dw_phase);

        // ---------------- asynchronous reset between edges ----------------
        @(posedge clk);
        #2;
        i_reset = 1'b0;
        #1;
        check_all("arst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        i_enable = 1'b0;
        i_reset  = 1'b1;
        repeat (3) tick();
        check_all("post_rst", 0, 0, 0, 0, 0, 0, 0);
        $display("async reset applied and released");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
